// File: rtl/cayde_wb_sched.sv
// Writeback scheduler: round-robin arbitration of ALU/LSU writebacks onto the single
// register-file write port, plus a scoreboard that stalls issue on RAW/WAW hazards.
module cayde_wb_sched #(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid_in,
    input  logic [4:0]             issue_rd_in,
    input  logic [4:0]             issue_rs1_in,
    input  logic [4:0]             issue_rs2_in,
    output logic                   issue_stall_out,
    input  logic                   wb0_valid_in,
    input  logic [4:0]             wb0_addr_in,
    input  logic [XLEN-1:0]        wb0_data_in,
    output logic                   wb0_ready_out,
    input  logic                   wb1_valid_in,
    input  logic [4:0]             wb1_addr_in,
    input  logic [XLEN-1:0]        wb1_data_in,
    output logic                   wb1_ready_out,
    input  logic                   flush_in,
    output logic                   rf_wen_out,
    output logic [4:0]             rf_waddr_out,
    output logic [XLEN-1:0]        rf_wdata_out,
    output logic [31:0]            busy_out,
    output logic [STALL_CNT_W-1:0] stall_cnt_out
);

    logic                   rr_r;
    logic                   grant0_s;
    logic                   grant1_s;
    logic                   accept_s;
    logic [4:0]             acc_addr_s;
    logic [XLEN-1:0]        acc_data_s;
    logic                   wen_r;
    logic [4:0]             waddr_r;
    logic [XLEN-1:0]        wdata_r;
    logic [31:0]            busy_r;
    logic [31:0]            busy_nxt_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   stall_s;
    logic                   issue_acc_s;

    // Scoreboard lookup; x0 can never be pending.
    function automatic logic busy_bit(input logic [31:0] vec, input logic [4:0] idx);
        logic hit;
        if (idx == 5'd0) begin
            hit = 1'b0;
        end else begin
            hit = vec[idx];
        end
        return hit;
    endfunction

    // Round-robin grant; rr_r set means wb1 owns the next tie.
    always_comb begin
        grant0_s   = 1'b0;
        grant1_s   = 1'b0;
        if (!rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (wb0_valid_in && wb1_valid_in) begin
            grant0_s = !rr_r;
            grant1_s = rr_r;
        end else begin
            grant0_s = wb0_valid_in;
            grant1_s = wb1_valid_in;
        end
        accept_s = grant0_s || grant1_s;
        if (grant1_s) begin
            acc_addr_s = wb1_addr_in;
            acc_data_s = wb1_data_in;
        end else begin
            acc_addr_s = wb0_addr_in;
            acc_data_s = wb0_data_in;
        end
    end

    // Hazard detection against registered scoreboard only.
    always_comb begin
        stall_s     = issue_valid_in && (busy_bit(busy_r, issue_rs1_in) ||
                                         busy_bit(busy_r, issue_rs2_in) ||
                                         busy_bit(busy_r, issue_rd_in));
        issue_acc_s = issue_valid_in && !stall_s;
    end

    // Scoreboard next state: commit clears, issue sets (set wins), flush overrides both.
    always_comb begin
        busy_nxt_s = busy_r;
        if (wen_r) begin
            busy_nxt_s[waddr_r] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (issue_acc_s && (issue_rd_in != 5'd0)) begin
            busy_nxt_s[issue_rd_in] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (flush_in) begin
            busy_nxt_s = 32'd0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Arbitration pointer moves only on an actual grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_r <= 1'b0;
        end else if (accept_s) begin
            rr_r <= grant0_s;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Write stage: x0 transfers are accepted but never reach the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_r   <= 1'b0;
            waddr_r <= 5'd0;
            wdata_r <= {XLEN{1'b0}};
        end else if (accept_s && (acc_addr_s != 5'd0)) begin
            wen_r   <= 1'b1;
            waddr_r <= acc_addr_s;
            wdata_r <= acc_data_s;
        end else begin
            wen_r   <= 1'b0;
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
        end
    end

    // Scoreboard and saturating stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r      <= 32'd0;
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            if (stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign wb0_ready_out   = grant0_s;
    assign wb1_ready_out   = grant1_s;
    assign issue_stall_out = stall_s;
    assign rf_wen_out      = wen_r;
    assign rf_waddr_out    = waddr_r;
    assign rf_wdata_out    = wdata_r;
    assign busy_out        = busy_r;
    assign stall_cnt_out   = stall_cnt_r;

endmodule

// File: tb/tb_cayde_wb_sched.sv
// Scoreboard bench for cayde_wb_sched: directed scenarios followed by random traffic,
// checked against a cycle-level reference model of arbitration and hazard tracking.
module tb_cayde_wb_sched;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        issue_valid, issue_stall;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic        flush;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic [15:0] stall_cnt;

    cayde_wb_sched #(.XLEN(32), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .issue_valid_in(issue_valid), .issue_rd_in(issue_rd),
        .issue_rs1_in(issue_rs1), .issue_rs2_in(issue_rs2),
        .issue_stall_out(issue_stall),
        .wb0_valid_in(wb0_valid), .wb0_addr_in(wb0_addr), .wb0_data_in(wb0_data),
        .wb0_ready_out(wb0_ready),
        .wb1_valid_in(wb1_valid), .wb1_addr_in(wb1_addr), .wb1_data_in(wb1_data),
        .wb1_ready_out(wb1_ready),
        .flush_in(flush),
        .rf_wen_out(rf_wen), .rf_waddr_out(rf_waddr), .rf_wdata_out(rf_wdata),
        .busy_out(busy), .stall_cnt_out(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus intent; requesters keep addr/data while still pending
    bit          v0, v1, iv, fl;
    logic [4:0]  a0, a1, ird, irs1, irs2;
    logic [31:0] d0, d1;

    // reference model
    wr_t         exp_q[$];
    logic [31:0] busy_m;
    int          last_grant;
    int          cnt_m;
    bit          infl_v;
    logic [4:0]  infl_a;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        busy_m     = 32'd0;
        last_grant = 1;
        cnt_m      = 0;
        infl_v     = 1'b0;
        infl_a     = 5'd0;
        v0 = 1'b0; v1 = 1'b0; iv = 1'b0; fl = 1'b0;
        a0 = 5'd0; a1 = 5'd0; d0 = 32'd0; d1 = 32'd0;
        ird = 5'd0; irs1 = 5'd0; irs2 = 5'd0;
    endtask

    task automatic req0(input logic [4:0] a, input logic [31:0] d);
        if (!v0) begin v0 = 1'b1; a0 = a; d0 = d; end
    endtask

    task automatic req1(input logic [4:0] a, input logic [31:0] d);
        if (!v1) begin v1 = 1'b1; a1 = a; d1 = d; end
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        iv = 1'b1; ird = rd; irs1 = rs1; irs2 = rs2;
    endtask

    task automatic idle();
        iv = 1'b0; fl = 1'b0;
    endtask

    // One clock: check registered state, apply stimulus, check combinational outputs, advance model.
    task automatic step();
        bit g0, g1, stall_m;
        logic [31:0] nb;
        @(negedge clk);
        check("busy_out", busy, busy_m);
        check("stall_cnt", stall_cnt, cnt_m);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
        issue_valid = iv; issue_rd = ird; issue_rs1 = irs1; issue_rs2 = irs2;
        flush = fl;
        #1;
        g0 = v0 && (!v1 || last_grant == 1);
        g1 = v1 && !g0;
        stall_m = iv && (busy_m[irs1] || busy_m[irs2] || busy_m[ird]);
        check("wb0_ready", wb0_ready, g0);
        check("wb1_ready", wb1_ready, g1);
        check("issue_stall", issue_stall, stall_m);
        nb = busy_m;
        if (infl_v) nb[infl_a] = 1'b0;
        if (iv && !stall_m && ird != 5'd0) nb[ird] = 1'b1;
        if (fl) nb = 32'd0;
        busy_m = nb;
        infl_v = 1'b0;
        if (g0) begin
            last_grant = 0;
            if (a0 != 5'd0) begin exp_q.push_back('{a: a0, d: d0}); infl_v = 1'b1; infl_a = a0; end
            v0 = 1'b0;
        end
        if (g1) begin
            last_grant = 1;
            if (a1 != 5'd0) begin exp_q.push_back('{a: a1, d: d1}); infl_v = 1'b1; infl_a = a1; end
            v1 = 1'b0;
        end
        if (stall_m && cnt_m < 65535) cnt_m++;
    endtask

    // Monitor: every expected write must appear as exactly one rf_wen pulse the next cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (rf_wen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {59'd0, rf_waddr}, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("rf_waddr", rf_waddr, e.a);
                    check("rf_wdata", rf_wdata, e.d);
                end
            end else if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("missing_write", 64'd0, {59'd0, e.a});
            end
        end
    end

    initial begin
        rst = 1'b0;
        model_reset();
        wb0_valid = 1'b0; wb1_valid = 1'b0; issue_valid = 1'b0; flush = 1'b0;
        wb0_addr = 5'd0; wb1_addr = 5'd0; wb0_data = 32'd0; wb1_data = 32'd0;
        issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_wen", rf_wen, 1'b0);
        check("reset_waddr", rf_waddr, 5'd0);
        check("reset_wdata", rf_wdata, 32'd0);

        // single write latency
        issue(5'd3, 5'd0, 5'd0); step();
        idle(); req0(5'd3, 32'h0000_1234); step();
        step(); step();

        // round-robin with both requesters continuously valid
        for (int i = 0; i < 4; i++) begin
            req0(5'd10 + 5'(i), 32'hA000_0000 + i);
            req1(5'd20 + 5'(i), 32'hB000_0000 + i);
            step();
        end
        v0 = 1'b0; v1 = 1'b0; step(); step();

        // RAW stall on x7, x0 source never stalls
        issue(5'd7, 5'd0, 5'd0); step();
        issue(5'd0, 5'd7, 5'd0); step(); step(); step();
        req1(5'd7, 32'h7777_7777); step();
        step(); step();
        issue(5'd0, 5'd0, 5'd0); step();

        // x0 write
        idle(); req1(5'd0, 32'hFFFF_FFFF); step(); step();

        // flush with an in-flight commit for x9
        issue(5'd1, 5'd0, 5'd0); step();
        issue(5'd2, 5'd0, 5'd0); step();
        issue(5'd9, 5'd0, 5'd0); step();
        idle(); fl = 1'b1; issue(5'd4, 5'd0, 5'd0); req1(5'd9, 32'h9999_0009); step();
        idle(); step(); step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!v0 && $urandom_range(0, 1) == 1) req0(5'($urandom_range(0, 7)), $urandom);
            if (!v1 && $urandom_range(0, 1) == 1) req1(5'($urandom_range(0, 7)), $urandom);
            iv   = ($urandom_range(0, 1) == 1);
            ird  = 5'($urandom_range(0, 7));
            irs1 = 5'($urandom_range(0, 7));
            irs2 = 5'($urandom_range(0, 7));
            fl   = ($urandom_range(0, 31) == 0);
            step();
        end
        idle(); v0 = 1'b0; v1 = 1'b0;
        step(); step();

        // reset asserted between acceptance and the write edge
        @(negedge clk);
        wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEAD_BEEF;
        wb1_valid = 1'b0; issue_valid = 1'b0; flush = 1'b0;
        #1;
        check("midrst_ready_before", wb0_ready, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_wen", rf_wen, 1'b0);
        check("midrst_busy", busy, 32'd0);
        check("midrst_ready", wb0_ready, 1'b0);
        check("midrst_cnt", stall_cnt, 16'd0);
        @(negedge clk);
        check("midrst_wen_hold", rf_wen, 1'b0);
        check("midrst_waddr", rf_waddr, 5'd0);
        wb0_valid = 1'b0;
        model_reset();
        rst = 1'b1;
        step(); step();

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
